// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the multicycle controller.
// Owns the PC and instruction register and runs a variable-latency
// request/valid handshake to instruction memory, with redirect support.
// Optional build macro FETCH_MISALIGN_CHK_EN adds a misalign output and
// suppresses requests at non-word-aligned PCs; without it the low two
// address bits are forced to zero on the memory side.

package fetch_unit_pkg;
  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_FENCE  = 7'b0001111,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } rv32i_opcode_t;
endpackage

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  input  logic              pc_load,
  input  logic [WIDTH-1:0]  pc_target,
  output logic              imem_req,
  output logic [WIDTH-1:0]  imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_rvalid,
  output logic [31:0]       instr,
  output rv32i_opcode_t     opcode,
  output logic [WIDTH-1:0]  pc,
  output logic [WIDTH-1:0]  instr_pc,
  output logic              fetch_done,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic              misalign,
`endif
  output logic              busy
);

  localparam logic [31:0]      NOP     = 32'h00000013;
  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state;
  logic   kill;      // in-flight response belongs to a redirected-away fetch
  logic   issue_ok;  // the PC about to enter REQ may be sent to memory

`ifdef FETCH_MISALIGN_CHK_EN
  // A request is only issued when the PC it will use is word aligned
  assign issue_ok  = ((pc_load ? pc_target[1:0] : pc[1:0]) == 2'b00);
  assign imem_addr = pc;
`else
  // Memory always sees a word address; the PC itself is left untouched
  assign issue_ok  = 1'b1;
  assign imem_addr = {pc[WIDTH-1:2], 2'b00};
`endif

  // Opcode is a plain view of the low instruction bits
  assign opcode = rv32i_opcode_t'(instr[6:0]);

  // Fetch FSM with registered request/done/busy outputs and PC/IR ownership
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      kill       <= 1'b0;
      pc         <= RESET_PC;
      instr_pc   <= RESET_PC;
      instr      <= NOP;
      imem_req   <= 1'b0;
      fetch_done <= 1'b0;
      busy       <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign   <= 1'b0;
`endif
    end else begin
      imem_req   <= 1'b0;
      fetch_done <= 1'b0;
      case (state)
        IDLE: begin
          // A same-cycle redirect is applied first so the fetch uses it
          if (pc_load) pc <= pc_target;
          if (fetch_start) begin
            state    <= REQ;
            busy     <= 1'b1;
            imem_req <= issue_ok;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign <= 1'b0;
`endif
          end
        end
        REQ: begin
`ifdef FETCH_MISALIGN_CHK_EN
          if (pc[1:0] != 2'b00) begin
            // No memory access: complete at once with an illegal instruction
            state      <= DONE;
            fetch_done <= 1'b1;
            misalign   <= 1'b1;
            instr      <= 32'h00000000;
            instr_pc   <= pc;
            if (pc_load) pc <= pc_target;
          end else
`endif
          begin
            // Response (if any) cannot arrive this cycle; a redirect here
            // orphans the request that is going out right now
            state <= WAIT;
            if (pc_load) begin
              pc   <= pc_target;
              kill <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (pc_load) pc <= pc_target;
          if (imem_rvalid) begin
            if (kill || pc_load) begin
              // Stale response: drop it and re-issue at the redirected PC
              state    <= REQ;
              kill     <= 1'b0;
              imem_req <= issue_ok;
            end else begin
              instr      <= imem_rdata;
              instr_pc   <= pc;
              pc         <= pc + PC_STEP;
              state      <= DONE;
              fetch_done <= 1'b1;
            end
          end else if (pc_load) begin
            kill <= 1'b1;
          end
        end
        DONE: begin
          // A redirect here overrides the sequential increment
          if (pc_load) pc <= pc_target;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized bench for fetch_unit. The bench plays
// instruction memory itself and tracks the architectural PC / IR / fetch PC
// that every completed or redirected fetch should leave behind.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fetch_start = 1'b0;
  logic          pc_load = 1'b0;
  logic [31:0]   pc_target = '0;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic          imem_rvalid = 1'b0;
  logic [31:0]   instr;
  rv32i_opcode_t opcode;
  logic [31:0]   pc;
  logic [31:0]   instr_pc;
  logic          fetch_done;
  logic          busy;
`ifdef FETCH_MISALIGN_CHK_EN
  logic          misalign;
`endif

  int tests = 0;
  int fails = 0;

  // Reference architectural state
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_instr = 32'h00000013;
  logic [31:0] m_ipc   = 32'h0;

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_start (fetch_start),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .instr       (instr),
    .opcode      (opcode),
    .pc          (pc),
    .instr_pc    (instr_pc),
    .fetch_done  (fetch_done),
`ifdef FETCH_MISALIGN_CHK_EN
    .misalign    (misalign),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Launch from IDLE; returns at the negedge of the REQ cycle
  task automatic start(input logic ld, input logic [31:0] tgt);
    fetch_start = 1'b1;
    pc_load     = ld;
    pc_target   = tgt;
    @(negedge clk);
    fetch_start = 1'b0;
    pc_load     = 1'b0;
  endtask

  // Called at the REQ-cycle negedge; runs the memory side to completion
  task automatic complete(input logic [31:0] addr, input int waits, input logic [31:0] data,
                          input logic done_ld, input logic [31:0] done_tgt);
    check("req_pulse", imem_req, 1);
    check("req_addr", imem_addr, addr & 32'hFFFF_FFFC);
    check("req_pc", pc, addr);
    check("req_busy", busy, 1);
    check("req_nodone", fetch_done, 0);
    fetch_start = 1'($urandom_range(0, 1));
    imem_rvalid = 1'($urandom_range(0, 1));
    imem_rdata  = $urandom;
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      check("wait_noreq", imem_req, 0);
      check("wait_nodone", fetch_done, 0);
      check("wait_instr", instr, m_instr);
      fetch_start = 1'($urandom_range(0, 1));
      imem_rvalid = (i == waits);
      imem_rdata  = (i == waits) ? data : $urandom;
    end
    @(negedge clk);
    imem_rvalid = 1'b0;
    fetch_start = 1'($urandom_range(0, 1));
    pc_load     = done_ld;
    pc_target   = done_tgt;
    check("done_pulse", fetch_done, 1);
    check("done_instr", instr, data);
    check("done_opcode", 32'(opcode), 32'(data[6:0]));
    check("done_ipc", instr_pc, addr);
    check("done_pc", pc, addr + 32'd4);
    m_instr = data;
    m_ipc   = addr;
    m_pc    = done_ld ? done_tgt : addr + 32'd4;
    @(negedge clk);
    fetch_start = 1'b0;
    pc_load     = 1'b0;
    check("idle_nodone", fetch_done, 0);
    check("idle_busy", busy, 0);
    check("idle_pc", pc, m_pc);
    check("idle_noreq", imem_req, 0);
    $display("[TB] fetch addr=%08h waits=%0d data=%08h -> pc=%08h", addr, waits, data, pc);
  endtask

  task automatic fetch(input logic ld, input logic [31:0] tgt, input int waits,
                       input logic [31:0] data, input logic done_ld, input logic [31:0] done_tgt);
    logic [31:0] a;
    a = ld ? tgt : m_pc;
    start(ld, tgt);
    complete(a, waits, data, done_ld, done_tgt);
  endtask

  // Fetch redirected while in flight (in REQ or after pre_waits WAIT cycles)
  task automatic killed_fetch(input logic in_req, input int pre_waits, input logic [31:0] new_tgt,
                              input int stale_waits, input int waits, input logic [31:0] data);
    logic [31:0] a0;
    a0 = m_pc;
    start(1'b0, 32'h0);
    check("k_req", imem_req, 1);
    check("k_addr", imem_addr, a0 & 32'hFFFF_FFFC);
    if (!in_req) begin
      for (int i = 0; i <= pre_waits; i++) begin
        @(negedge clk);
        check("k_prewait_noreq", imem_req, 0);
      end
    end
    pc_load   = 1'b1;
    pc_target = new_tgt;
    for (int j = 0; j <= stale_waits; j++) begin
      @(negedge clk);
      pc_load = 1'b0;
      check("k_pc", pc, new_tgt);
      check("k_nodone", fetch_done, 0);
      check("k_noreq", imem_req, 0);
      check("k_instr", instr, m_instr);
      imem_rvalid = (j == stale_waits);
      imem_rdata  = 32'hDEADBEEF;
    end
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("k_instr_kept", instr, m_instr);
    check("k_ipc_kept", instr_pc, m_ipc);
    $display("[TB] redirect in_req=%0d from=%08h to=%08h (stale response dropped)", in_req, a0, new_tgt);
    complete(new_tgt, waits, data, 1'b0, 32'h0);
  endtask

  task automatic idle_load(input logic [31:0] tgt);
    pc_load   = 1'b1;
    pc_target = tgt;
    @(negedge clk);
    pc_load = 1'b0;
    m_pc    = tgt;
    check("iload_pc", pc, tgt);
    check("iload_busy", busy, 0);
    $display("[TB] idle redirect pc=%08h", pc);
  endtask

  initial begin
    // Reset
    @(negedge clk);
    @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_ipc", instr_pc, 32'h0);
    check("rst_instr", instr, 32'h00000013);
    check("rst_opcode", 32'(opcode), 32'h13);
    check("rst_req", imem_req, 0);
    check("rst_done", fetch_done, 0);
    check("rst_busy", busy, 0);
`ifdef FETCH_MISALIGN_CHK_EN
    check("rst_misalign", misalign, 0);
`endif
    rst = 1'b1;
    @(negedge clk);
    $display("[TB] reset released");

    // First fetch, one wait cycle
    fetch(1'b0, 32'h0, 1, 32'h00500093, 1'b0, 32'h0);
    check("op_imm", 32'(opcode), 32'(OP_IMM));

    // Back-to-back with 0/3/7 wait cycles
    fetch(1'b0, 32'h0, 0, 32'h00A00113, 1'b0, 32'h0);
    fetch(1'b0, 32'h0, 3, 32'h002081B3, 1'b0, 32'h0);
    fetch(1'b0, 32'h0, 7, 32'h0000006F, 1'b0, 32'h0);
    check("pc_after_three", pc, 32'd16);

    // Redirect together with fetch_start in IDLE
    fetch(1'b1, 32'h100, 2, 32'h00000037, 1'b0, 32'h0);
    check("pc_after_redirect", pc, 32'h104);

    // Redirect during WAIT with a stale response
    killed_fetch(1'b0, 1, 32'h40, 1, 2, 32'h00C00213);
    check("pc_after_kill", pc, 32'h44);

    // Redirect during REQ
    killed_fetch(1'b1, 0, 32'h80, 0, 1, 32'h00100073);

    // Redirect during DONE overrides the increment
    fetch(1'b0, 32'h0, 0, 32'h00000513, 1'b1, 32'h200);

    // Randomized mix
    for (int n = 0; n < 30; n++) begin
      int op;
      logic [31:0] t;
      op = int'($urandom_range(0, 4));
      t  = $urandom & 32'hFFFF_FFFC;
      case (op)
        0: fetch(1'b0, 32'h0, int'($urandom_range(0, 5)), $urandom, 1'b0, 32'h0);
        1: fetch(1'b1, t, int'($urandom_range(0, 5)), $urandom, 1'b0, 32'h0);
        2: killed_fetch(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), t,
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), $urandom);
        3: idle_load(t);
        default: fetch(1'b0, 32'h0, int'($urandom_range(0, 3)), $urandom, 1'b1, t);
      endcase
    end

    // PC wrap at the top of the address space
    fetch(1'b1, 32'hFFFF_FFFC, 2, 32'h00000013, 1'b0, 32'h0);
    check("pc_wrap", pc, 32'h0);

`ifndef FETCH_MISALIGN_CHK_EN
    // Misaligned PC: memory sees the word address, PC keeps its low bits
    fetch(1'b1, 32'h206, 1, 32'h00700393, 1'b0, 32'h0);
    check("unaligned_pc", pc, 32'h20A);
`endif

    // Reset asserted mid-fetch
    start(1'b0, 32'h0);
    @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("mrst_pc", pc, 32'h0);
    check("mrst_req", imem_req, 0);
    check("mrst_instr", instr, 32'h00000013);
    check("mrst_ipc", instr_pc, 32'h0);
    check("mrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    m_pc = 32'h0; m_instr = 32'h00000013; m_ipc = 32'h0;
    $display("[TB] reset asserted during WAIT");
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hCAFEF00D;
    @(negedge clk);
    imem_rvalid = 1'b0;
    @(negedge clk);
    check("stray_instr", instr, 32'h00000013);
    check("stray_done", fetch_done, 0);
    check("stray_busy", busy, 0);
    check("stray_pc", pc, 32'h0);
    $display("[TB] stray rvalid in IDLE ignored");

`ifdef FETCH_MISALIGN_CHK_EN
    // Misaligned request is suppressed and flagged
    idle_load(32'h102);
    start(1'b0, 32'h0);
    check("mis_noreq", imem_req, 0);
    check("mis_busy", busy, 1);
    @(negedge clk);
    check("mis_done", fetch_done, 1);
    check("mis_flag", misalign, 1);
    check("mis_instr", instr, 32'h0);
    check("mis_pc", pc, 32'h102);
    @(negedge clk);
    check("mis_sticky", misalign, 1);
    check("mis_idle", busy, 0);
    m_instr = 32'h0;
    $display("[TB] misaligned fetch pc=%08h flagged", pc);
    start(1'b1, 32'h100);
    check("mis_clear", misalign, 0);
    complete(32'h100, 1, 32'h00000093, 1'b0, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the multicycle controller.
- Owns the PC and the instruction register, and runs a variable-latency request/valid handshake to instruction memory.
- Presents the captured instruction, its opcode (rv32i_opcode_t) and its PC to the controller and datapath.
- Accepts PC redirects for jumps and branches, including a redirect that arrives while a fetch is in flight.

Parameters:
- WIDTH, 32, address/PC width in bits (>= 3).
- RESET_PC, 0, PC value loaded on reset (WIDTH bits, word-aligned).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- fetch_start  in  1  controller request to fetch the instruction at pc.
- pc_load  in  1  redirect strobe.
- pc_target  in  WIDTH  redirect address.
- imem_req  out  1  memory read request, one-cycle pulse.
- imem_addr  out  WIDTH  memory read address; valid while imem_req=1.
- imem_rdata  in  32  memory read data.
- imem_rvalid  in  1  imem_rdata valid this cycle.
- instr  out  32  instruction register.
- opcode  out  7  instr[6:0], typed rv32i_opcode_t.
- pc  out  WIDTH  address of the next fetch.
- instr_pc  out  WIDTH  address the current instr was fetched from.
- fetch_done  out  1  one-cycle pulse: new instr is valid.
- busy  out  1  fetch in progress (state != IDLE).

Behaviour:
- Reset values (async assert, sync release):
  - pc=RESET_PC, instr_pc=RESET_PC, instr=32'h00000013 (NOP, opcode OP_IMM).
  - imem_req=0, fetch_done=0, busy=0, state=IDLE, kill=0.
- FSM states: IDLE, REQ, WAIT, DONE. busy=1 in REQ/WAIT/DONE.
- IDLE:
  - fetch_start=1 -> REQ.
  - pc_load=1 -> pc<=pc_target.
  - fetch_start and pc_load together: pc<=pc_target, then REQ, so the fetch uses pc_target.
- REQ:
  - imem_req=1, imem_addr=pc for exactly one cycle, then WAIT.
  - Memory never returns rvalid in the REQ cycle; a returning rvalid there is ignored.
- WAIT:
  - Hold until imem_rvalid=1. No timeout; unbounded wait-states are legal.
  - On rvalid with kill=0: instr<=imem_rdata, instr_pc<=pc, pc<=pc+4 (mod 2^WIDTH, wrap), then DONE.
- DONE: fetch_done=1 for one cycle, then IDLE.
- Minimum latency: fetch_start sampled at edge N -> imem_req in cycle N+1 -> rvalid in cycle N+2 -> fetch_done in cycle N+3.
- Redirect while busy:
  - pc_load in REQ or WAIT: kill<=1 and the target is stored in pc.
  - The in-flight response (rvalid) is consumed and discarded: instr, instr_pc and pc are unchanged, no fetch_done.
  - FSM then returns to REQ and re-issues at the new pc, with kill cleared.
  - pc_load in DONE: pc<=pc_target (overrides the +4), no refetch.
  - The latest pc_load wins when several arrive.
- fetch_start while busy is ignored (not queued).
- opcode is purely combinational from instr.
- Reset mid-fetch: all state returns to reset values immediately. A later stray rvalid in IDLE is ignored.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- When defined:
  - Extra output port misalign (1 bit, reset 0).
  - A request with pc[1:0]!=0 is not issued: REQ -> DONE directly, no imem_req, misalign=1 together with fetch_done.
  - instr is loaded with 32'h00000000 (decodes to an illegal opcode); pc is unchanged.
  - misalign clears on the next fetch_start.
- When undefined:
  - No misalign port.
  - imem_addr is issued with pc[1:0] forced to 0; the fetch proceeds normally.

Test Plan:
- Reset, release, pulse fetch_start; memory returns 32'h00500093 after 1 wait cycle -> imem_addr=0, instr=32'h00500093, opcode=OP_IMM, instr_pc=0, pc=4, fetch_done exactly one cycle.
- Three back-to-back fetches with 0/3/7 wait cycles -> imem_addr 4,8,12 in order; pc ends at 16; one fetch_done per fetch; fetch_start during busy has no effect.
- In IDLE, pc_load=1 with pc_target=32'h100 and fetch_start=1 in the same cycle -> imem_addr=32'h100; after fetch pc=32'h104.
- pc_load with pc_target=32'h40 during WAIT; stale rvalid data 32'hDEADBEEF -> instr unchanged, no fetch_done, new imem_req at 32'h40, fetch completes with pc=32'h44.
- pc=32'hFFFFFFFC fetch -> pc wraps to 0. Assert rst low during WAIT -> pc=RESET_PC, imem_req=0, instr=32'h00000013 immediately.
- With FETCH_MISALIGN_CHK_EN: pc_load with pc_target=32'h102, then fetch_start -> no imem_req, misalign=1, fetch_done=1, instr=0, pc=32'h102.
